// File: rtl/mem_access_stage.sv
// MEM stage: data-memory req/ready handshake, pipeline stall, MEM/WB register.
// Ports: EX/MEM inputs, mem_* bus, stall, MEM/WB outputs, error pulses.
module mem_access_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] alu_in,
  input  logic [31:0] wdata_in,
  input  logic [4:0]  rd_in,
  input  logic        RegWrite_in,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic        MemToReg_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        stall,
  output logic [31:0] alu_out,
  output logic [31:0] rdata_out,
  output logic [4:0]  rd_out,
  output logic        RegWrite_out,
  output logic        MemToReg_out,
  output logic        misalign_err,
  output logic        bus_err
);

  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  logic mem_op;
  logic aligned;
  logic access;
  logic misalign;
  logic is_load;
  logic timeout_hit;

  assign mem_op   = MemRead_in | MemWrite_in;
  assign aligned  = (alu_in[1:0] == 2'b00);
  assign access   = mem_op & aligned;
  assign misalign = mem_op & ~aligned;
  // Write wins when both control bits are set.
  assign is_load  = access & MemRead_in & ~MemWrite_in;

  // Ready in the last allowed cycle still completes normally.
  assign timeout_hit = (state == WAIT) & access & ~mem_ready &
                       (cnt == CNT_LAST);

  assign mem_req   = access;
  assign mem_we    = access & MemWrite_in;
  assign mem_addr  = {alu_in[31:2], 2'b00};
  assign mem_wdata = wdata_in;
  assign stall     = access & ~mem_ready & ~timeout_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      alu_out      <= '0;
      rdata_out    <= '0;
      rd_out       <= '0;
      RegWrite_out <= 1'b0;
      MemToReg_out <= 1'b0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (access & ~mem_ready) state <= WAIT;
        WAIT: if (~stall) state <= IDLE;
        default: state <= IDLE;
      endcase

      // Counts request cycles without ready; first one is seen in IDLE.
      if (stall) cnt <= cnt + 1'b1;
      else       cnt <= '0;

      misalign_err <= misalign;
      bus_err      <= timeout_hit;

      unique case (1'b1)
        stall: begin
          rd_out       <= '0;
          RegWrite_out <= 1'b0;
          MemToReg_out <= 1'b0;
        end
        timeout_hit: begin
          alu_out      <= alu_in;
          rdata_out    <= 32'hDEAD_BEEF;
          rd_out       <= rd_in;
          RegWrite_out <= 1'b0;
          MemToReg_out <= MemToReg_in;
        end
        default: begin
          alu_out      <= alu_in;
          if (is_load) rdata_out <= mem_rdata;
          rd_out       <= rd_in;
          RegWrite_out <= RegWrite_in & ~misalign;
          MemToReg_out <= MemToReg_in;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

MEM-stage controller for the 5-stage pipelined MIPS core: consumes the EX/MEM pipeline register outputs, runs the data-memory transaction over a req/ready handshake, stalls the front of the pipeline while memory is busy, and registers the MEM/WB pipeline outputs. It also detects misaligned word accesses and bus timeouts, and squashes the affected writeback.

## Interface
- TIMEOUT, 16: maximum number of cycles `mem_req` is held without `mem_ready` before the access is aborted. Legal range is ≥2.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- alu_in  in  32  effective address for loads/stores, or the ALU result for non-memory ops (EX/MEM `alu_out`).
- wdata_in  in  32  store data (EX/MEM `wdata_out`).
- rd_in  in  5  destination register.
- RegWrite_in, MemRead_in, MemWrite_in, MemToReg_in  in  1 each  control bits from EX/MEM.
- mem_req  out  1  memory request, combinational.
- mem_we  out  1  1 = write; equals MemWrite_in while `mem_req` is high, else 0.
- mem_addr  out  32  equals `{alu_in[31:2],2'b00}`.
- mem_wdata  out  32  equals `wdata_in`.
- mem_rdata  in  32  read data; valid when `mem_ready` is high.
- mem_ready  in  1  completes the current request in the same cycle.
- stall  out  1  combinational; holds PC, IF/ID, ID/EX and EX/MEM.
- alu_out, rdata_out  out  32 each  MEM/WB register: ALU result and load data.
- rd_out  out  5  MEM/WB destination register.
- RegWrite_out, MemToReg_out  out  1 each  MEM/WB control bits.
- misalign_err, bus_err  out  1 each  registered one-cycle error pulses.

## Operation
- `access` = (MemRead_in | MemWrite_in) & (alu_in[1:0]==0). If both read and write bits are set, the access is treated as a write.
- `misalign` = (MemRead_in | MemWrite_in) & (alu_in[1:0]!=0). No request is issued. The instruction passes to MEM/WB with RegWrite_out=0, and misalign_err pulses on the next cycle.
- FSM states and transitions:
  - IDLE → WAIT when `access` & !mem_ready.
  - IDLE stays in IDLE if the access completes in the same cycle, or if there is no access.
  - WAIT → IDLE on mem_ready, or on timeout.
  - Wait counter `cnt`:
    - cleared in IDLE;
    - incremented on each cycle with mem_req & !mem_ready;
    - width is $clog2(TIMEOUT)+1.
- mem_req = `access` in both IDLE and WAIT. It remains asserted continuously until completion or abort, and address/data are held stable by the upstream stall.
- timeout_hit = WAIT & !mem_ready & (cnt == TIMEOUT-1). When both arrive in the same cycle, mem_ready takes priority over timeout.
- stall = `access` & !mem_ready & !timeout_hit.
- MEM/WB update, every edge unless reset:
  - **stall=1:** load a bubble (RegWrite_out=0, MemToReg_out=0, rd_out=0; data regs don't-care, hold).
  - **Normal completion:** alu_out←alu_in, rdata_out←mem_rdata (for loads; hold for others), rd_out←rd_in, RegWrite_out←RegWrite_in, MemToReg_out←MemToReg_in.
  - **Timeout abort:** same as normal, but RegWrite_out←0, rdata_out←32'hDEADBEEF, and bus_err pulses. An aborted store is dropped (memory side sees mem_req fall without ready).
- Non-memory instructions: no request and no stall; the stage passes through with 1-cycle latency.

## Timing
- Reset, applied synchronously at the edge: state=IDLE, cnt=0, and alu_out, rdata_out, rd_out, RegWrite_out, MemToReg_out, misalign_err and bus_err all 0. The combinational outputs follow from the inputs: mem_req, mem_we and stall are 0 once state=IDLE, given idle inputs.
- A reset asserted mid-WAIT aborts the transaction. It does not raise bus_err, and mem_req drops in the cycle after the reset edge unless a new access is presented.
- Zero-wait memory (mem_ready high in the request cycle): no stall, and the load result appears in MEM/WB after 1 edge.
- N wait cycles: stall is high for N cycles, and MEM/WB captures on the edge of the ready cycle.
- Maximum stall is TIMEOUT-1 cycles; mem_req is high for TIMEOUT cycles in total.
- Back-to-back accesses: a new access may assert mem_req in the cycle immediately after completion, with no idle gap.
- Error pulses are high for exactly one cycle, coincident with the MEM/WB update of the faulting instruction.

## Test plan
- **Zero-wait load:** alu_in=0x100, MemRead=1, RegWrite=1, rd=8, ready in the same cycle, rdata=0x12345678 → stall never high; next cycle rdata_out=0x12345678, rd_out=8, RegWrite_out=1.
- **Store, 3 wait states:** alu_in=0x204, wdata=0xCAFEF00D, ready on the 4th cycle → mem_req/mem_we high for 4 cycles with addr/wdata stable; stall high for 3 cycles; MEM/WB shows bubbles during the stall, then the store entry with RegWrite_out=0.
- **Misaligned load:** alu_in=0x102, MemRead=1 → mem_req stays 0, stall stays 0; next cycle misalign_err=1 and RegWrite_out=0.
- **Timeout:** TIMEOUT=16, load, ready held low → mem_req high for 16 cycles; stall high for 15 cycles; bus_err pulses; rdata_out=0xDEADBEEF, RegWrite_out=0.
- **Ready coincides with timeout:** ready asserted in the 16th request cycle → normal completion, bus_err=0.
- **Reset mid-WAIT:** reset after 2 wait cycles → next cycle all outputs 0, state IDLE, bus_err stays 0; a following zero-wait load then completes normally.
